stage_wb: RTL and testbench
===========================

# stage_wb

Writeback stage of the five-stage RISC-V pipeline and the producer side of the decode stage's register-file write port. It registers the instruction leaving the memory stage, waits for the variable-latency data-memory response on loads, and performs byte/halfword extraction with sign or zero extension. It selects the final writeback value and drives the one-cycle register-file write pulse (`rd_addr_out`, `rd_wen_out`, `wb_out`) into decode. It also stalls upstream while a load is outstanding and counts retired instructions.

## Interface
- `WORD_WIDTH`, 32, datapath width (`WORD_WIDTH` from constants.vh)
- `INS_ADDR_WIDTH`, 32, PC width (`MEM_ADDR_WIDTH`)
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  memory stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `alu_res`  in  WORD_WIDTH  ALU result / load address
- `pc_addr_in`  in  INS_ADDR_WIDTH  PC of the instruction
- `rd_addr_in`  in  REG_ADDR_WIDTH  destination register
- `rd_wen_in`  in  1  instruction writes rd
- `wb_ctl`  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- `byt_typ`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `dmem_rvalid`  in  1  load data valid this cycle
- `dmem_rdata`  in  WORD_WIDTH  aligned word from data memory
- `rd_addr_out`  out  REG_ADDR_WIDTH  regfile write address
- `rd_wen_out`  out  1  regfile write enable, one-cycle pulse
- `wb_out`  out  WORD_WIDTH  regfile write data
- `stall_en`  out  1  hold upstream stages
- `retire_cnt`  out  32  retired-instruction count

## Operation
- FSM states are IDLE and WAIT_LOAD. `in_ready` = (state == IDLE). `stall_en` = (state == WAIT_LOAD).
- Acceptance occurs on `in_valid & in_ready`. The instruction is captured into a holding register (alu_res, pc, rd, wen, wb_ctl, byt_typ).
- Non-load accepted: compute the value and retire at the next edge. ALU selects `alu_res`; PC+4 selects `pc_addr_in + 4`, zero-extended or truncated to WORD_WIDTH.
- Load accepted with `dmem_rvalid` high the same cycle: retire at the next edge and stay in IDLE.
- Load accepted without `dmem_rvalid`: go to WAIT_LOAD.
- In WAIT_LOAD, when `dmem_rvalid` is seen: retire at the next edge and return to IDLE. `in_ready` stays 0 in the rvalid cycle itself.
- Load extraction:
  - byte lane = alu_res[1:0]; halfword lane = alu_res[1] (alu_res[0] ignored); word ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined byt_typ (011, 110, 111) is treated as LW.
- Retire: `rd_wen_out` = held wen & (held rd != 0). `rd_addr_out` and `wb_out` are registered alongside it. `rd_wen_out` is high for exactly one cycle per retire and low otherwise; `wb_out` and `rd_addr_out` hold their last value.
- `retire_cnt` increments by 1 on every retire, including rd_wen=0 and rd=x0. It wraps 0xFFFFFFFF → 0.
- `dmem_rvalid` is ignored in IDLE when no load is being accepted.
- `in_valid` is ignored while in WAIT_LOAD.

## Timing
- Reset: state IDLE; `rd_wen_out`=0, `rd_addr_out`=0, `wb_out`=0, `retire_cnt`=0; `in_ready`=1 and `stall_en`=0 the cycle after reset.
- `rst` mid-WAIT_LOAD discards the pending load: no write, no count.
- `rst` has priority over every event in the same cycle.
- Latency: accept at cycle N (non-load, or load with rvalid) → write visible at N+1.
- Load with rvalid at cycle M > N → write visible at M+1; `stall_en` high in cycles N+1..M.
- Throughput is one non-load instruction per cycle.
- `in_ready` and `stall_en` are purely state-decoded; there is no combinational path from inputs to them.
- Decode's regfile samples the write at the edge after the pulse. Same-cycle read-after-write bypass is decode's concern.

## Test plan
- Back-to-back ALU ops: (rd=5, 0x1234), (rd=6, 0xDEADBEEF) on consecutive cycles → `rd_wen_out` pulses at N+1 and N+2 with the matching addr/data; `retire_cnt`=2.
- LB with alu_res=0x...03, rdata=0x80FF_0000, rvalid same cycle → wb_out=0xFFFF_FF80 at N+1; LBU on the same data → 0x0000_0080.
- LH with alu_res[1]=1, rdata=0x8001_7FFF, rvalid 3 cycles after accept → `stall_en` high 3 cycles, `in_ready` low, then wb_out=0xFFFF_8001.
- JAL with pc=0x100, wb_ctl=10, rd=1 → wb_out=0x104. The same instruction with rd=0 → no `rd_wen_out` pulse, but `retire_cnt` increments.
- `rst` asserted in WAIT_LOAD, then rvalid → no write; state IDLE; all outputs 0.
- Preload `retire_cnt` to 0xFFFFFFFF via 2^32−1 retires (or a force), then one retire → 0.

Source files
------------

// File: rtl/stage_wb.sv
// -----------------------------------------------------------------------------
// stage_wb -- writeback stage of the five-stage RISC-V pipeline.
//
// Accepts one instruction per cycle from the memory stage. It waits for the
// data-memory response on loads, and extracts bytes or halfwords with sign or
// zero extension. It then drives a registered one-cycle register-file write
// pulse into decode.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        memory stage presents an instruction
//   in_ready        stage can accept (state-decoded, IDLE)
//   alu_res         ALU result / load address
//   pc_addr_in      PC of the instruction (used for PC+4 writeback)
//   rd_addr_in      destination register
//   rd_wen_in       instruction writes rd
//   wb_ctl          00 ALU, 01 load, 10 PC+4, 11 ALU
//   byt_typ         load funct3 (LB/LH/LW/LBU/LHU, others act as LW)
//   dmem_rvalid     load data valid this cycle
//   dmem_rdata      aligned word from data memory
//   rd_addr_out     regfile write address (held between retires)
//   rd_wen_out      regfile write enable, one-cycle pulse per retire
//   wb_out          regfile write data (held between retires)
//   stall_en        hold upstream while a load is outstanding
//   retire_cnt      retired-instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module stage_wb #(
   parameter int WORD_WIDTH     = 32,
   parameter int INS_ADDR_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WORD_WIDTH-1:0]     alu_res,
   input  logic [INS_ADDR_WIDTH-1:0] pc_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
   input  logic                      rd_wen_in,
   input  logic [1:0]                wb_ctl,
   input  logic [2:0]                byt_typ,
   input  logic                      dmem_rvalid,
   input  logic [WORD_WIDTH-1:0]     dmem_rdata,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
   output logic                      rd_wen_out,
   output logic [WORD_WIDTH-1:0]     wb_out,
   output logic                      stall_en,
   output logic [31:0]               retire_cnt
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_e;

   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Extracts the addressed byte/halfword from an aligned word. Undefined
   // funct3 encodings fall through to a full-word load.
   function automatic logic [WORD_WIDTH-1:0] load_extract(
      input logic [2:0]            f3,
      input logic [1:0]            offset,
      input logic [WORD_WIDTH-1:0] data
   );
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = data[{offset, 3'b000} +: 8];
      half_v = offset[1] ? data[16 +: 16] : data[0 +: 16];
      case (f3)
         F3_LB:   load_extract = {{(WORD_WIDTH-8){byte_v[7]}}, byte_v};
         F3_LH:   load_extract = {{(WORD_WIDTH-16){half_v[15]}}, half_v};
         F3_LBU:  load_extract = {{(WORD_WIDTH-8){1'b0}}, byte_v};
         F3_LHU:  load_extract = {{(WORD_WIDTH-16){1'b0}}, half_v};
         default: load_extract = data;
      endcase
   endfunction

   state_e state_q, state_d;

   // Holding register for the instruction accepted from the memory stage.
   logic [WORD_WIDTH-1:0]     hold_alu_q;
   logic [INS_ADDR_WIDTH-1:0] hold_pc_q;
   logic [REG_ADDR_WIDTH-1:0] hold_rd_q;
   logic                      hold_wen_q;
   logic [1:0]                hold_ctl_q;
   logic [2:0]                hold_byt_q;

   logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                      rd_wen_q, rd_wen_d;
   logic [WORD_WIDTH-1:0]     wb_q, wb_d;
   logic [31:0]               retire_cnt_q, retire_cnt_d;

   logic                      capture;
   logic                      retire;

   // Fields of the instruction being retired this cycle: straight from the
   // inputs when accepting in IDLE, from the holding register in WAIT_LOAD.
   logic [WORD_WIDTH-1:0]     cur_alu;
   logic [INS_ADDR_WIDTH-1:0] cur_pc;
   logic [REG_ADDR_WIDTH-1:0] cur_rd;
   logic                      cur_wen;
   logic [1:0]                cur_ctl;
   logic [2:0]                cur_byt;
   logic [INS_ADDR_WIDTH-1:0] cur_pc4;
   logic [WORD_WIDTH-1:0]     cur_val;

   // Handshake outputs are decoded from state only.
   assign in_ready = (state_q == IDLE);
   assign stall_en = (state_q == WAIT_LOAD);

   // NOTE: every signal written in an always_comb gets a default at the top;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      retire  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               capture = 1'b1;
               if ((wb_ctl == WB_LOAD) && !dmem_rvalid) begin
                  state_d = WAIT_LOAD;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         WAIT_LOAD: begin
            if (dmem_rvalid) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (state_q == IDLE) begin
         cur_alu = alu_res;
         cur_pc  = pc_addr_in;
         cur_rd  = rd_addr_in;
         cur_wen = rd_wen_in;
         cur_ctl = wb_ctl;
         cur_byt = byt_typ;
      end else begin
         cur_alu = hold_alu_q;
         cur_pc  = hold_pc_q;
         cur_rd  = hold_rd_q;
         cur_wen = hold_wen_q;
         cur_ctl = hold_ctl_q;
         cur_byt = hold_byt_q;
      end

      // PC+4 is computed at PC width then zero-extended or truncated.
      cur_pc4 = cur_pc + INS_ADDR_WIDTH'(4);
      case (cur_ctl)
         WB_LOAD: cur_val = load_extract(cur_byt, cur_alu[1:0], dmem_rdata);
         WB_PC4:  cur_val = WORD_WIDTH'(cur_pc4);
         default: cur_val = cur_alu;
      endcase

      // Address/data only move on a retire so they hold between pulses;
      // a write to x0 still retires but never raises the enable.
      rd_wen_d     = retire & cur_wen & (cur_rd != '0);
      rd_addr_d    = retire ? cur_rd  : rd_addr_q;
      wb_d         = retire ? cur_val : wb_q;
      retire_cnt_d = retire_cnt_q + {31'b0, retire};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_wen_q     <= 1'b0;
         rd_addr_q    <= '0;
         wb_q         <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         rd_wen_q     <= rd_wen_d;
         rd_addr_q    <= rd_addr_d;
         wb_q         <= wb_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // NOTE: the holding register is deliberately not reset; it is only read in
   // WAIT_LOAD, which can only be entered after a capture has loaded it.
   always_ff @(posedge clk) begin
      if (capture) begin
         hold_alu_q <= alu_res;
         hold_pc_q  <= pc_addr_in;
         hold_rd_q  <= rd_addr_in;
         hold_wen_q <= rd_wen_in;
         hold_ctl_q <= wb_ctl;
         hold_byt_q <= byt_typ;
      end
   end

   assign rd_addr_out = rd_addr_q;
   assign rd_wen_out  = rd_wen_q;
   assign wb_out      = wb_q;
   assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_stage_wb.sv
// -----------------------------------------------------------------------------
// tb_stage_wb -- self-checking bench for stage_wb.
//
// A transaction-level model (one optional pending load plus the last retired
// write) predicts the outputs every cycle; directed sequences with literal
// expectations pin the model, then randomized traffic exercises the rest.
// -----------------------------------------------------------------------------
module tb_stage_wb;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  alu_res;
   logic [AW-1:0] pc_addr_in;
   logic [RW-1:0] rd_addr_in;
   logic          rd_wen_in;
   logic [1:0]    wb_ctl;
   logic [2:0]    byt_typ;
   logic          dmem_rvalid;
   logic [W-1:0]  dmem_rdata;
   logic [RW-1:0] rd_addr_out;
   logic          rd_wen_out;
   logic [W-1:0]  wb_out;
   logic          stall_en;
   logic [31:0]   retire_cnt;

   always #5 clk = ~clk;

   stage_wb #(.WORD_WIDTH(W), .INS_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_res     (alu_res),
      .pc_addr_in  (pc_addr_in),
      .rd_addr_in  (rd_addr_in),
      .rd_wen_in   (rd_wen_in),
      .wb_ctl      (wb_ctl),
      .byt_typ     (byt_typ),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .rd_addr_out (rd_addr_out),
      .rd_wen_out  (rd_wen_out),
      .wb_out      (wb_out),
      .stall_en    (stall_en),
      .retire_cnt  (retire_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [31:0] alu;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  ctl;
      logic [2:0]  byt;
   } instr_t;

   bit          live = 1'b0;     // model valid once a reset has been seen
   bit          pending = 1'b0;  // a load is waiting for its data
   instr_t      pend;
   bit          m_wen = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [31:0] m_wb = '0;
   logic [31:0] m_cnt = '0;
   bit          hold_ok = 1'b1;  // addr/data are known (last retire wrote)
   int          preload_tok = 0;
   int          preload_seen = 0;

   function automatic logic [31:0] model_load(input logic [2:0] f3,
                                              input logic [31:0] addr,
                                              input logic [31:0] d);
      logic [31:0] v;
      int          sh;
      sh = 8 * int'(addr[1:0]);
      case (f3)
         3'd0, 3'd4: begin
            v = (d >> sh) & 32'h0000_00FF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            v = addr[1] ? (d >> 16) : (d & 32'h0000_FFFF);
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_value(input instr_t i, input logic [31:0] rdata);
      if (i.ctl == 2'b01) return model_load(i.byt, i.alu, rdata);
      if (i.ctl == 2'b10) return i.pc + 32'd4;
      return i.alu;
   endfunction

   always @(posedge clk) begin : model
      instr_t cur;
      bit     ret;
      if (preload_tok != preload_seen) begin
         m_cnt        = 32'hFFFF_FFFF;
         preload_seen = preload_tok;
      end
      ret = 1'b0;
      if (rst) begin
         live    = 1'b1;
         pending = 1'b0;
         m_wen   = 1'b0;
         m_rd    = '0;
         m_wb    = '0;
         m_cnt   = '0;
         hold_ok = 1'b1;
      end else begin
         m_wen = 1'b0;
         if (!pending) begin
            if (in_valid) begin
               cur = '{alu_res, pc_addr_in, rd_addr_in, rd_wen_in, wb_ctl, byt_typ};
               if (cur.ctl == 2'b01 && !dmem_rvalid) begin
                  pending = 1'b1;
                  pend    = cur;
               end else begin
                  ret = 1'b1;
               end
            end
         end else if (dmem_rvalid) begin
            cur     = pend;
            pending = 1'b0;
            ret     = 1'b1;
         end
         if (ret) begin
            m_cnt   = m_cnt + 32'd1;
            m_rd    = cur.rd;
            m_wb    = model_value(cur, dmem_rdata);
            m_wen   = cur.wen && (cur.rd != 5'd0);
            hold_ok = m_wen;
         end
      end
   end

   // Compare process: outputs are sampled mid-cycle, away from the edge.
   always @(negedge clk) begin
      if (live) begin
         check("in_ready",   32'(in_ready),   32'(!pending));
         check("stall_en",   32'(stall_en),   32'(pending));
         check("rd_wen_out", 32'(rd_wen_out), 32'(m_wen));
         check("retire_cnt", retire_cnt,      m_cnt);
         if (hold_ok) begin
            check("rd_addr_out", 32'(rd_addr_out), 32'(m_rd));
            check("wb_out",      wb_out,           m_wb);
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] ctl, input logic [2:0] f3,
                        input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                        input logic [31:0] pc, input logic rv, input logic [31:0] rdata);
      in_valid    = v;
      wb_ctl      = ctl;
      byt_typ     = f3;
      rd_addr_in  = rd;
      rd_wen_in   = wen;
      alu_res     = alu;
      pc_addr_in  = pc;
      dmem_rvalid = rv;
      dmem_rdata  = rdata;
   endtask

   task automatic quiet();
      drive(1'b0, 2'b00, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      quiet();
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      check("rst in_ready",   32'(in_ready),    32'd1);
      check("rst stall_en",   32'(stall_en),    32'd0);
      check("rst rd_wen_out", 32'(rd_wen_out),  32'd0);
      check("rst rd_addr",    32'(rd_addr_out), 32'd0);
      check("rst wb_out",     wb_out,           32'd0);
      check("rst retire_cnt", retire_cnt,       32'd0);

      // Back-to-back ALU ops.
      drive(1'b1, 2'b00, 3'b000, 5'd5, 1'b1, 32'h0000_1234, 32'h40, 1'b0, 32'h0);
      tick();
      check("alu1 wen",  32'(rd_wen_out),  32'd1);
      check("alu1 rd",   32'(rd_addr_out), 32'd5);
      check("alu1 data", wb_out,           32'h0000_1234);
      drive(1'b1, 2'b00, 3'b000, 5'd6, 1'b1, 32'hDEAD_BEEF, 32'h44, 1'b0, 32'h0);
      tick();
      check("alu2 wen",  32'(rd_wen_out),  32'd1);
      check("alu2 rd",   32'(rd_addr_out), 32'd6);
      check("alu2 data", wb_out,           32'hDEAD_BEEF);
      quiet();
      tick();
      check("alu idle wen", 32'(rd_wen_out), 32'd0);
      check("alu cnt",      retire_cnt,      32'd2);
      check("alu hold data", wb_out,         32'hDEAD_BEEF);

      // LB / LBU with same-cycle data.
      drive(1'b1, 2'b01, 3'b000, 5'd7, 1'b1, 32'h0000_1003, 32'h48, 1'b1, 32'h80FF_0000);
      tick();
      check("lb data", wb_out, 32'hFFFF_FF80);
      check("lb wen",  32'(rd_wen_out), 32'd1);
      drive(1'b1, 2'b01, 3'b100, 5'd8, 1'b1, 32'h0000_1003, 32'h4C, 1'b1, 32'h80FF_0000);
      tick();
      check("lbu data", wb_out, 32'h0000_0080);
      check("lbu cnt",  retire_cnt, 32'd4);

      // LH with data three cycles after accept.
      drive(1'b1, 2'b01, 3'b001, 5'd9, 1'b1, 32'h0000_2002, 32'h50, 1'b0, 32'h0);
      tick();
      quiet();
      in_valid = 1'b1;  // ignored while waiting
      for (int k = 0; k < 3; k++) begin
         check("lh stall_en", 32'(stall_en), 32'd1);
         check("lh in_ready", 32'(in_ready), 32'd0);
         check("lh no wen",   32'(rd_wen_out), 32'd0);
         if (k == 2) begin
            in_valid    = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'h8001_7FFF;
         end
         tick();
      end
      quiet();
      check("lh data",  wb_out, 32'hFFFF_8001);
      check("lh rd",    32'(rd_addr_out), 32'd9);
      check("lh ready", 32'(in_ready), 32'd1);
      check("lh cnt",   retire_cnt, 32'd5);

      // JAL: rd=1 writes PC+4; rd=0 retires silently.
      drive(1'b1, 2'b10, 3'b000, 5'd1, 1'b1, 32'h0, 32'h0000_0100, 1'b0, 32'h0);
      tick();
      check("jal data", wb_out, 32'h0000_0104);
      check("jal wen",  32'(rd_wen_out), 32'd1);
      drive(1'b1, 2'b10, 3'b000, 5'd0, 1'b1, 32'h0, 32'h0000_0100, 1'b0, 32'h0);
      tick();
      quiet();
      check("jal x0 wen", 32'(rd_wen_out), 32'd0);
      check("jal x0 cnt", retire_cnt, 32'd7);

      // Reset while a load is pending, with data arriving in the reset cycle.
      drive(1'b1, 2'b01, 3'b010, 5'd10, 1'b1, 32'h0, 32'h60, 1'b0, 32'h0);
      tick();
      check("pend stall", 32'(stall_en), 32'd1);
      quiet();
      rst         = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1111_2222;
      tick();
      rst = 1'b0;
      quiet();
      check("rstld wen",   32'(rd_wen_out),  32'd0);
      check("rstld rd",    32'(rd_addr_out), 32'd0);
      check("rstld data",  wb_out,           32'd0);
      check("rstld cnt",   retire_cnt,       32'd0);
      check("rstld ready", 32'(in_ready),    32'd1);
      dmem_rvalid = 1'b1;  // stray data in IDLE must be ignored
      tick();
      quiet();
      check("rstld late wen", 32'(rd_wen_out), 32'd0);
      check("rstld late cnt", retire_cnt,      32'd0);

      // Counter wrap: preload to all-ones, then one retire.
      @(negedge clk);
      #1;
      preload_tok++;
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      drive(1'b1, 2'b11, 3'b000, 5'd3, 1'b1, 32'h0000_0055, 32'h70, 1'b0, 32'h0);
      tick();
      quiet();
      check("wrap cnt",  retire_cnt, 32'd0);
      check("wrap data", wb_out, 32'h0000_0055);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 149) == 0);
         in_valid    = ($urandom_range(0, 9) < 7);
         wb_ctl      = 2'($urandom_range(0, 3));
         byt_typ     = 3'($urandom_range(0, 7));
         rd_addr_in  = 5'($urandom_range(0, 31));
         rd_wen_in   = 1'($urandom_range(0, 1));
         alu_res     = $urandom;
         pc_addr_in  = $urandom;
         dmem_rvalid = ($urandom_range(0, 9) < 4);
         dmem_rdata  = $urandom;
         tick();
      end
      rst = 1'b0;
      quiet();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
